// File: rtl/regfile_wr_arbiter_if.sv
// Purpose : bundles the two writeback requester handshakes and the shared
//           register-file write port of regfile_wr_arbiter.
// Signals : a_valid/a_ready/a_rd/a_data   requester A (ALU writeback)
//           b_valid/b_ready/b_rd/b_data   requester B (load writeback)
//           we_reg/rd/indata              register-file write port
//           pend_mask                     registers with an uncommitted write
//           wr_count                      issued register-file writes (wraps)
// Modports: master = requester/observer side, slave = arbiter side.
interface regfile_wr_arbiter_if #(
   parameter int REG_SIZE      = 32,
   parameter int REG_ADDR_SIZE = 5
);
   logic                     a_valid;
   logic                     a_ready;
   logic [REG_ADDR_SIZE-1:0] a_rd;
   logic [REG_SIZE-1:0]      a_data;
   logic                     b_valid;
   logic                     b_ready;
   logic [REG_ADDR_SIZE-1:0] b_rd;
   logic [REG_SIZE-1:0]      b_data;
   logic                     we_reg;
   logic [REG_ADDR_SIZE-1:0] rd;
   logic [REG_SIZE-1:0]      indata;
   logic [REG_SIZE-1:0]      pend_mask;
   logic [15:0]              wr_count;

   modport master (
      output a_valid, a_rd, a_data, b_valid, b_rd, b_data,
      input  a_ready, b_ready, we_reg, rd, indata, pend_mask, wr_count
   );

   modport slave (
      input  a_valid, a_rd, a_data, b_valid, b_rd, b_data,
      output a_ready, b_ready, we_reg, rd, indata, pend_mask, wr_count
   );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Purpose : shares the single register-file write port between two
//           writeback requesters, each with a one-entry holding slot.
//           Grants are age ordered with a round-robin tie-break; the
//           winning entry is registered onto we_reg/rd/indata.
// Ports   : clk        clock, rising edge
//           rst        asynchronous active-high reset
//           bus        regfile_wr_arbiter_if slave (handshakes, write port,
//                      pend_mask, wr_count)
//
// Age tracker (older_q), meaningful only while both slots are full:
//   state    | meaning
//   OLD_NONE | no defined order (loaded on the same edge) - rr_q decides
//   OLD_A    | slot A holds the older entry
//   OLD_B    | slot B holds the older entry
module regfile_wr_arbiter #(
   parameter int REG_SIZE      = 32,
   parameter int REG_ADDR_SIZE = 5
) (
   input logic                 clk,
   input logic                 rst,
   regfile_wr_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      OLD_NONE = 2'd0,
      OLD_A    = 2'd1,
      OLD_B    = 2'd2
   } older_t;

   typedef enum logic {
      RR_A = 1'b0,
      RR_B = 1'b1
   } rr_t;

   logic                     full_a_q, full_a_d;
   logic [REG_ADDR_SIZE-1:0] rd_a_q, rd_a_d;
   logic [REG_SIZE-1:0]      data_a_q, data_a_d;
   logic                     full_b_q, full_b_d;
   logic [REG_ADDR_SIZE-1:0] rd_b_q, rd_b_d;
   logic [REG_SIZE-1:0]      data_b_q, data_b_d;
   older_t                   older_q, older_d;
   rr_t                      rr_q, rr_d;
   logic                     we_q, we_d;
   logic [REG_ADDR_SIZE-1:0] rd_q, rd_d;
   logic [REG_SIZE-1:0]      indata_q, indata_d;
   logic [15:0]              wr_count_q, wr_count_d;

   logic                     grant_a, grant_b;
   logic                     ready_a, ready_b;
   logic                     load_a, load_b;
   logic [REG_ADDR_SIZE-1:0] grant_rd;
   logic [REG_SIZE-1:0]      grant_data;
   logic [REG_SIZE-1:0]      pend_mask;

   // Grant is a function of registered slot state only, so ready never
   // depends combinationally on valid.
   always_comb begin
      grant_a = 1'b0;
      grant_b = 1'b0;
      if (full_a_q && full_b_q) begin
         case (older_q)
            OLD_A:   grant_a = 1'b1;
            OLD_B:   grant_b = 1'b1;
            default: begin
               if (rr_q == RR_A) grant_a = 1'b1;
               else              grant_b = 1'b1;
            end
         endcase
      end else begin
         grant_a = full_a_q;
         grant_b = full_b_q;
      end
   end

   always_comb begin
      ready_a    = !rst && (!full_a_q || grant_a);
      ready_b    = !rst && (!full_b_q || grant_b);
      load_a     = bus.a_valid && ready_a;
      load_b     = bus.b_valid && ready_b;

      full_a_d   = load_a || (full_a_q && !grant_a);
      rd_a_d     = load_a ? bus.a_rd   : rd_a_q;
      data_a_d   = load_a ? bus.a_data : data_a_q;
      full_b_d   = load_b || (full_b_q && !grant_b);
      rd_b_d     = load_b ? bus.b_rd   : rd_b_q;
      data_b_d   = load_b ? bus.b_data : data_b_q;

      // A slot refilled while the other keeps waiting is the younger one.
      older_d = OLD_NONE;
      if (full_a_d && full_b_d) begin
         if (load_a && !load_b)      older_d = OLD_B;
         else if (load_b && !load_a) older_d = OLD_A;
         else if (!load_a && !load_b) older_d = older_q;
         else                        older_d = OLD_NONE;
      end

      rr_d = rr_q;
      if (grant_a)      rr_d = RR_B;
      else if (grant_b) rr_d = RR_A;

      grant_rd   = grant_a ? rd_a_q   : rd_b_q;
      grant_data = grant_a ? data_a_q : data_b_q;

      // x0 grants drain the slot but never reach the register file.
      we_d       = 1'b0;
      rd_d       = rd_q;
      indata_d   = indata_q;
      if (grant_a || grant_b) begin
         we_d     = (grant_rd != '0);
         rd_d     = grant_rd;
         indata_d = grant_data;
      end
      wr_count_d = we_d ? wr_count_q + 16'd1 : wr_count_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         full_a_q   <= 1'b0;
         rd_a_q     <= '0;
         data_a_q   <= '0;
         full_b_q   <= 1'b0;
         rd_b_q     <= '0;
         data_b_q   <= '0;
         older_q    <= OLD_NONE;
         rr_q       <= RR_A;
         we_q       <= 1'b0;
         rd_q       <= '0;
         indata_q   <= '0;
         wr_count_q <= '0;
      end else begin
         full_a_q   <= full_a_d;
         rd_a_q     <= rd_a_d;
         data_a_q   <= data_a_d;
         full_b_q   <= full_b_d;
         rd_b_q     <= rd_b_d;
         data_b_q   <= data_b_d;
         older_q    <= older_d;
         rr_q       <= rr_d;
         we_q       <= we_d;
         rd_q       <= rd_d;
         indata_q   <= indata_d;
         wr_count_q <= wr_count_d;
      end
   end

   // Every register that still has a write in a slot or on the port.
   always_comb begin
      pend_mask = '0;
      if (full_a_q) pend_mask = pend_mask | (REG_SIZE'(1) << rd_a_q);
      if (full_b_q) pend_mask = pend_mask | (REG_SIZE'(1) << rd_b_q);
      if (we_q)     pend_mask = pend_mask | (REG_SIZE'(1) << rd_q);
      pend_mask[0] = 1'b0;
   end

   assign bus.a_ready   = ready_a;
   assign bus.b_ready   = ready_b;
   assign bus.we_reg    = we_q;
   assign bus.rd        = rd_q;
   assign bus.indata    = indata_q;
   assign bus.pend_mask = pend_mask;
   assign bus.wr_count  = wr_count_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
module tb_regfile_wr_arbiter;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   regfile_wr_arbiter_if #(.REG_SIZE(32), .REG_ADDR_SIZE(5)) bus ();

   regfile_wr_arbiter #(.REG_SIZE(32), .REG_ADDR_SIZE(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int vectors     = 0;
   int miscompares = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: each slot carries the cycle number it was loaded
   // in; the lower number is older, equal numbers fall to round-robin.
   logic        m_fa, m_fb;
   logic [4:0]  m_ra, m_rb;
   logic [31:0] m_da, m_db;
   int          m_sa, m_sb, m_cyc;
   logic        m_rr_b;
   logic        m_we;
   logic [4:0]  m_rd;
   logic [31:0] m_in;
   logic [15:0] m_cnt;
   logic        m_ga, m_gb, m_rdy_a, m_rdy_b, m_la, m_lb;
   logic [4:0]  m_grd;
   logic [31:0] m_gdata, m_mask;

   always_comb begin
      m_ga    = m_fa && (!m_fb || (m_sa < m_sb) || (m_sa == m_sb && !m_rr_b));
      m_gb    = m_fb && !m_ga;
      m_rdy_a = !rst && (!m_fa || m_ga);
      m_rdy_b = !rst && (!m_fb || m_gb);
      m_la    = bus.a_valid && m_rdy_a;
      m_lb    = bus.b_valid && m_rdy_b;
      m_grd   = m_ga ? m_ra : m_rb;
      m_gdata = m_ga ? m_da : m_db;
      m_mask  = 32'd0;
      if (m_fa) m_mask[m_ra] = 1'b1;
      if (m_fb) m_mask[m_rb] = 1'b1;
      if (m_we) m_mask[m_rd] = 1'b1;
      m_mask[0] = 1'b0;
   end

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_fa <= 0; m_fb <= 0; m_ra <= 0; m_rb <= 0; m_da <= 0; m_db <= 0;
         m_sa <= 0; m_sb <= 0; m_cyc <= 0; m_rr_b <= 0;
         m_we <= 0; m_rd <= 0; m_in <= 0; m_cnt <= 0;
      end else begin
         m_cyc <= m_cyc + 1;
         if (m_la) begin
            m_fa <= 1'b1; m_ra <= bus.a_rd; m_da <= bus.a_data; m_sa <= m_cyc;
         end else if (m_ga) m_fa <= 1'b0;
         if (m_lb) begin
            m_fb <= 1'b1; m_rb <= bus.b_rd; m_db <= bus.b_data; m_sb <= m_cyc;
         end else if (m_gb) m_fb <= 1'b0;
         if (m_ga || m_gb) begin
            m_rr_b <= m_ga;
            m_rd   <= m_grd;
            m_in   <= m_gdata;
            m_we   <= (m_grd != 5'd0);
            if (m_grd != 5'd0) m_cnt <= m_cnt + 16'd1;
         end else begin
            m_we <= 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      chk("a_ready",   32'(bus.a_ready), 32'(m_rdy_a));
      chk("b_ready",   32'(bus.b_ready), 32'(m_rdy_b));
      chk("we_reg",    32'(bus.we_reg),  32'(m_we));
      chk("rd",        32'(bus.rd),      32'(m_rd));
      chk("indata",    bus.indata,       m_in);
      chk("pend_mask", bus.pend_mask,    m_mask);
      chk("wr_count",  32'(bus.wr_count), 32'(m_cnt));
   end

   // Register file image fed by the write port, to check final contents.
   logic [31:0] rf [32];
   always @(posedge clk) if (bus.we_reg) rf[bus.rd] <= bus.indata;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.a_valid = 0;
      bus.b_valid = 0;
   endtask

   task automatic do_reset();
      rst = 1;
      step();
      step();
      rst = 0;
      step();
   endtask

   task automatic drive_a(input logic [4:0] r, input logic [31:0] d);
      bus.a_valid = 1; bus.a_rd = r; bus.a_data = d;
   endtask

   task automatic drive_b(input logic [4:0] r, input logic [31:0] d);
      bus.b_valid = 1; bus.b_rd = r; bus.b_data = d;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int na, nb, nw, first_w, last_w, t;
      logic acc_a, acc_b;
      rst = 0;
      bus.a_valid = 0; bus.a_rd = 0; bus.a_data = 0;
      bus.b_valid = 0; bus.b_rd = 0; bus.b_data = 0;
      #1 rst = 1;
      step();
      step();
      chk("rst_we", 32'(bus.we_reg), 0);
      chk("rst_ready_a", 32'(bus.a_ready), 0);
      chk("rst_count", 32'(bus.wr_count), 0);
      rst = 0;
      step();

      // single write from A
      drive_a(5'd3, 32'hDEADBEEF);
      chk("t1_ready", 32'(bus.a_ready), 1);
      step();
      idle();
      chk("t1_pend_e0", 32'(bus.pend_mask[3]), 1);
      step();
      chk("t1_we", 32'(bus.we_reg), 1);
      chk("t1_rd", 32'(bus.rd), 3);
      chk("t1_data", bus.indata, 32'hDEADBEEF);
      chk("t1_pend_e1", 32'(bus.pend_mask[3]), 1);
      chk("t1_count", 32'(bus.wr_count), 1);
      step();
      chk("t1_we_off", 32'(bus.we_reg), 0);
      chk("t1_pend_clr", bus.pend_mask, 0);

      // simultaneous tie, twice to show rr back at A
      do_reset();
      drive_a(5'd5, 32'h11);
      drive_b(5'd6, 32'h22);
      step();
      idle();
      step();
      chk("t2_first_rd", 32'(bus.rd), 5);
      chk("t2_first_data", bus.indata, 32'h11);
      step();
      chk("t2_second_rd", 32'(bus.rd), 6);
      chk("t2_second_data", bus.indata, 32'h22);
      chk("t2_count", 32'(bus.wr_count), 2);
      drive_a(5'd8, 32'h33);
      drive_b(5'd9, 32'h44);
      step();
      idle();
      step();
      chk("t2_tie2_rd", 32'(bus.rd), 8);
      step();
      chk("t2_tie2_rd_b", 32'(bus.rd), 9);

      // age order with the same destination
      do_reset();
      drive_a(5'd9, 32'h01);
      drive_b(5'd7, 32'hAA);
      step();
      bus.b_valid = 0;
      drive_a(5'd7, 32'hBB);
      step();
      idle();
      chk("t3_w1_rd", 32'(bus.rd), 9);
      step();
      chk("t3_w2_rd", 32'(bus.rd), 7);
      chk("t3_w2_data", bus.indata, 32'hAA);
      step();
      chk("t3_w3_data", bus.indata, 32'hBB);
      chk("t3_rf_mid", rf[7], 32'hAA);
      step();
      chk("t3_rf_final", rf[7], 32'hBB);

      // x0 suppression
      do_reset();
      drive_a(5'd0, 32'h55);
      step();
      idle();
      chk("t4_pend0", bus.pend_mask, 0);
      step();
      chk("t4_we", 32'(bus.we_reg), 0);
      chk("t4_count", 32'(bus.wr_count), 0);
      chk("t4_ready", 32'(bus.a_ready), 1);
      drive_a(5'd4, 32'h66);
      step();
      idle();
      step();
      chk("t4_next_count", 32'(bus.wr_count), 1);

      // back-to-back streaming
      do_reset();
      na = 0; nb = 0; nw = 0; first_w = -1; last_w = -1; t = 0;
      while ((na < 10 || nb < 10) && t < 60) begin
         bus.a_valid = (na < 10); bus.a_rd = 5'(1 + na);  bus.a_data = 32'hA000_0000 + na;
         bus.b_valid = (nb < 10); bus.b_rd = 5'(11 + nb); bus.b_data = 32'hB000_0000 + nb;
         acc_a = bus.a_valid && bus.a_ready;
         acc_b = bus.b_valid && bus.b_ready;
         step();
         t++;
         if (acc_a) na++;
         if (acc_b) nb++;
         if (bus.we_reg) begin
            nw++;
            if (first_w < 0) first_w = t;
            last_w = t;
         end
      end
      idle();
      for (int k = 0; k < 6; k++) begin
         step();
         t++;
         if (bus.we_reg) begin
            nw++;
            if (first_w < 0) first_w = t;
            last_w = t;
         end
      end
      chk("t5_acc_a", na, 10);
      chk("t5_acc_b", nb, 10);
      chk("t5_writes", nw, 20);
      chk("t5_no_gaps", last_w - first_w + 1, 20);
      chk("t5_count", 32'(bus.wr_count), 20);

      // reset mid-flight
      do_reset();
      drive_a(5'd1, 32'h101);
      drive_b(5'd2, 32'h202);
      step();
      bus.b_valid = 0;
      drive_a(5'd3, 32'h303);
      step();
      idle();
      chk("t6_we_before", 32'(bus.we_reg), 1);
      chk("t6_pend_before", bus.pend_mask, 32'h0000_000E);
      rst = 1;
      #1;
      chk("t6_rst_we", 32'(bus.we_reg), 0);
      chk("t6_rst_rd", 32'(bus.rd), 0);
      chk("t6_rst_indata", bus.indata, 0);
      chk("t6_rst_pend", bus.pend_mask, 0);
      chk("t6_rst_count", 32'(bus.wr_count), 0);
      chk("t6_rst_ready_a", 32'(bus.a_ready), 0);
      chk("t6_rst_ready_b", 32'(bus.b_ready), 0);
      @(negedge clk);
      #1 rst = 0;
      for (int k = 0; k < 4; k++) begin
         step();
         chk("t6_after_we", 32'(bus.we_reg), 0);
         chk("t6_after_ready", 32'({bus.a_ready, bus.b_ready}), 3);
      end
      chk("t6_after_count", 32'(bus.wr_count), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
